// File: rtl/detect_run_monitor_pkg.sv
// detect_run_monitor_pkg: shared state encoding and default widths for the detection-run monitor.
package detect_run_monitor_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_LEN_W = 8;
endpackage

// File: rtl/detect_run_monitor_sat_counter.sv
// sat_counter: saturating up-counter with clear, load-to-one and sync active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : load ? W'(1) : (inc && q_q != '1) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/detect_run_monitor.sv
// detect_run_monitor: counts detect rising edges and reports each run length on a valid/ready port.
module detect_run_monitor
  import detect_run_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             clear,
  input  logic             run_ready,
  output logic             run_valid,
  output logic [LEN_W-1:0] run_len,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             busy
);
  state_e state_q, state_d;
  logic rise, fall, grow, accept, store;
  logic run_valid_q, run_valid_d, overflow_q, overflow_d;
  logic [LEN_W-1:0] len_q, run_len_q, run_len_d;
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = detect ? RUN : IDLE;
  always_comb begin
    rise = state_q == IDLE && detect;
    fall = state_q == RUN && !detect;
    grow = state_q == RUN && detect;
  end
  sat_counter #(.W(LEN_W)) u_len (
    .clk(clk), .reset(reset), .clr(1'b0), .load(rise), .inc(grow), .q(len_q)
  );
  sat_counter #(.W(CNT_W)) u_evt (
    .clk(clk), .reset(reset), .clr(clear), .load(1'b0), .inc(rise), .q(evt_count)
  );
  // A finished run only lands if the slot is empty or being drained this same edge.
  always_comb begin
    accept      = run_valid_q && run_ready;
    store       = fall && (!run_valid_q || accept);
    run_valid_d = clear ? 1'b0 : store ? 1'b1 : accept ? 1'b0 : run_valid_q;
    run_len_d   = (!clear && store) ? len_q : run_len_q;
    overflow_d  = clear ? 1'b0 : (fall && !store) ? 1'b1 : overflow_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_valid_q <= 1'b0;
      run_len_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      run_valid_q <= run_valid_d;
      run_len_q   <= run_len_d;
      overflow_q  <= overflow_d;
    end
  end
  assign run_valid = run_valid_q;
  assign run_len   = run_len_q;
  assign overflow  = overflow_q;
  assign busy      = state_q == RUN;
endmodule

// File: tb/tb_detect_run_monitor.sv
// tb_detect_run_monitor: vector table, corner sequences and randomized run against a reference model.
module tb_detect_run_monitor;
  logic clk = 0, reset = 0, detect = 0, clear = 0, run_ready = 0;
  logic run_valid, overflow, busy;
  logic [7:0] run_len, evt_count;
  int checks = 0, failures = 0;
  bit m_in_run, m_valid, m_ovf;
  int m_cur, m_evt, m_len;

  detect_run_monitor #(.CNT_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .detect(detect), .clear(clear), .run_ready(run_ready),
    .run_valid(run_valid), .run_len(run_len), .evt_count(evt_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic d; logic c; logic r;
    logic v; int len; int evt; logic o; logic b;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a run is a maximal stretch of sampled detect=1; its length is clipped at 255.
  task automatic model_edge();
    bit acc;
    if (!reset) begin
      m_in_run = 0; m_cur = 0; m_evt = 0; m_valid = 0; m_len = 0; m_ovf = 0;
      return;
    end
    acc = m_valid && run_ready;
    if (clear) begin
      m_evt = 0; m_ovf = 0; m_valid = 0;
    end else begin
      if (!m_in_run && detect) m_evt = (m_evt + 1 > 255) ? 255 : m_evt + 1;
      if (m_in_run && !detect) begin
        if (!m_valid || acc) begin m_valid = 1; m_len = m_cur; end
        else m_ovf = 1;
      end else if (acc) m_valid = 0;
    end
    if (detect) m_cur = m_in_run ? ((m_cur + 1 > 255) ? 255 : m_cur + 1) : 1;
    m_in_run = detect;
  endtask

  task automatic tick(input logic rst, input logic d, input logic c, input logic r);
    reset = rst; detect = d; clear = c; run_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model();
    chk("rnd_valid", run_valid, m_valid);
    if (m_valid) chk("rnd_len", run_len, m_len);
    chk("rnd_evt", evt_count, m_evt);
    chk("rnd_ovf", overflow, m_ovf);
    chk("rnd_busy", busy, m_in_run);
  endtask

  task automatic add(input logic rst, d, c, r, v, input int len, evt, input logic o, b);
    tv.push_back('{rst, d, c, r, v, len, evt, o, b});
  endtask

  initial begin
    //  rst d c r   v len evt o b
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 3, 1, 0, 0);
    add(1, 0, 0, 1, 0, 3, 1, 0, 0);
    add(1, 1, 0, 0, 0, 3, 2, 0, 1);
    add(1, 1, 0, 0, 0, 3, 2, 0, 1);
    add(1, 0, 0, 0, 1, 2, 2, 0, 0);
    add(1, 0, 0, 0, 1, 2, 2, 0, 0);
    add(1, 1, 0, 0, 1, 2, 3, 0, 1);
    add(1, 1, 0, 0, 1, 2, 3, 0, 1);
    add(1, 1, 0, 0, 1, 2, 3, 0, 1);
    add(1, 1, 0, 0, 1, 2, 3, 0, 1);
    add(1, 0, 0, 0, 1, 2, 3, 1, 0);
    add(1, 0, 0, 1, 0, 2, 3, 1, 0);
    add(1, 0, 0, 0, 0, 2, 3, 1, 0);
    add(1, 1, 0, 0, 0, 2, 4, 1, 1);
    add(1, 1, 0, 0, 0, 2, 4, 1, 1);
    add(1, 1, 0, 0, 0, 2, 4, 1, 1);
    add(1, 1, 0, 0, 0, 2, 4, 1, 1);
    add(1, 1, 0, 0, 0, 2, 4, 1, 1);
    add(1, 0, 1, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1, 1, 2, 0, 1);
    add(1, 1, 0, 0, 1, 1, 2, 0, 1);
    add(1, 0, 0, 1, 1, 2, 2, 0, 0);
    add(1, 0, 0, 1, 0, 2, 2, 0, 0);
    add(1, 1, 0, 0, 0, 2, 3, 0, 1);
    add(1, 1, 1, 0, 0, 2, 0, 0, 1);
    add(1, 0, 0, 0, 1, 2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, 2, 0, 0, 1);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      tick(tv[i].rst, tv[i].d, tv[i].c, tv[i].r);
      chk($sformatf("vec%0d_valid", i), run_valid, tv[i].v);
      chk($sformatf("vec%0d_len", i), run_len, tv[i].len);
      chk($sformatf("vec%0d_evt", i), evt_count, tv[i].evt);
      chk($sformatf("vec%0d_ovf", i), overflow, tv[i].o);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].b);
    end

    tick(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) tick(1, 1, 0, 1);
    chk("long_valid_during", run_valid, 0);
    chk("long_busy", busy, 1);
    tick(1, 0, 0, 1);
    chk("long_valid", run_valid, 1);
    chk("long_len_sat", run_len, 255);
    chk("long_evt", evt_count, 1);

    tick(0, 0, 0, 1);
    for (int i = 0; i < 257; i++) begin
      tick(1, 1, 0, 1);
      tick(1, 0, 0, 1);
      if (i == 253) chk("evt_254", evt_count, 254);
      if (i == 254) chk("evt_255", evt_count, 255);
    end
    chk("evt_sat", evt_count, 255);
    chk("evt_sat_len", run_len, 1);
    chk("evt_sat_ovf", overflow, 0);

    tick(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1);
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
